// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants (PARITY state used only with UART_TX_PARITY_EN)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int MIN_BAUD_DIV = 2;

  // Mode 2'b11 is treated like PAR_NONE.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous transmit FIFO with occupancy count
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (level == LVL_W'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART transmitter: FIFO, baud/bit counters, frame FSM
// Optional parity bit built only when UART_TX_PARITY_EN is defined.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic                          stop2,
  input  logic [1:0]                    parity_mode,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(MIN_BAUD_DIV);

  uart_state_e           state;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DIV_WIDTH-1:0]  baud_cnt;
  logic [DIV_WIDTH-1:0]  period_q;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  stop2_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  push;
  logic                  bit_end;
  logic                  last_stop;
  logic                  frame_start;

  assign s_ready = !fifo_full;
  assign push    = s_valid && s_ready;
  assign busy    = (state != IDLE) || (fifo_level != '0);

  assign bit_end     = (baud_cnt == period_q - 1'b1);
  // In STOP, bit_cnt counts completed stop bits.
  assign last_stop   = (state == STOP) && bit_end && (!stop2_q || (bit_cnt != '0));
  assign frame_start = !fifo_empty && ((state == IDLE) || last_stop);

  uart_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (frame_start),
    .wdata (s_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_bit_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (frame_start) begin
      par_en_q  <= parity_enabled(parity_mode);
      par_bit_q <= (parity_mode == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
    end
  end
`else
  logic unused_parity;
  assign unused_parity = ^parity_mode;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shift_q  <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      period_q <= MIN_DIV;
      stop2_q  <= 1'b0;
    end else if (frame_start) begin
      // Frame settings are sampled once here and held for the whole frame.
      state    <= START;
      tx       <= 1'b0;
      shift_q  <= fifo_rdata;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      period_q <= (baud_div < MIN_DIV) ? MIN_DIV : baud_div;
      stop2_q  <= stop2;
    end else if (state != IDLE) begin
      if (!bit_end) begin
        baud_cnt <= baud_cnt + 1'b1;
      end else begin
        baud_cnt <= '0;
        unique case (state)
          START: begin
            state   <= DATA;
            tx      <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_cnt <= '0;
          end
          DATA: begin
            if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              if (par_en_q) begin
                state <= PARITY;
                tx    <= par_bit_q;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            state   <= STOP;
            tx      <= 1'b1;
            bit_cnt <= '0;
          end
`endif
          STOP: begin
            if (last_stop) begin
              state <= IDLE;
              tx    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - directed bench for uart_tx_core; parity steps need UART_TX_PARITY_EN
module tb_uart_tx_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] baud_div;
  logic        stop2;
  logic [1:0]  parity_mode;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_level;

  int total = 0;
  int bad   = 0;
  logic cap_q[$];
  logic exp_q[$];

  uart_tx_core #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .DIV_WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .baud_div    (baud_div),
    .stop2       (stop2),
    .parity_mode (parity_mode),
    .tx          (tx),
    .busy        (busy),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_cap(input int n);
    repeat (n) begin
      tick();
      cap_q.push_back(tx);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // par < 0 means no parity bit.
  task automatic add_frame(input logic [7:0] d, input int p, input int nstop, input int par);
    logic [7:0] dv;
    dv = d;
    repeat (p) exp_q.push_back(1'b0);
    for (int b = 0; b < 8; b++) repeat (p) exp_q.push_back(dv[b]);
    if (par >= 0) repeat (p) exp_q.push_back(par[0]);
    repeat (p * nstop) exp_q.push_back(1'b1);
  endtask

  task automatic cmp_stream(input string tag);
    int errs;
    int n;
    errs = 0;
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    chk({tag, "_len"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) if (cap_q[i] !== exp_q[i]) errs++;
    chk({tag, "_bits"}, errs, 0);
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic push1(input logic [7:0] d);
    s_data  = d;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
  endtask

  initial begin
    int lows;
    int busy_hi;
    rst_n       = 1'b0;
    s_data      = '0;
    s_valid     = 1'b0;
    baud_div    = 16'd4;
    stop2       = 1'b0;
    parity_mode = 2'b00;
    tick(3);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", s_ready, 1'b1);
    chk("rst_level", fifo_level, 3'd0);
    rst_n = 1'b1;
    tick(2);
    chk("idle_tx", tx, 1'b1);

    // Single 0xA5 frame at 4 clocks per bit.
    push1(8'hA5);
    chk("a5_busy_on_push", busy, 1'b1);
    chk("a5_level_on_push", fifo_level, 3'd1);
    chk("a5_tx_before_start", tx, 1'b1);
    tick_cap(40);
    chk("a5_busy_last_clk", busy, 1'b1);
    add_frame(8'hA5, 4, 1, -1);
    cmp_stream("a5_frame");
    tick();
    chk("a5_busy_fall", busy, 1'b0);
    tick(3);

`ifdef UART_TX_PARITY_EN
    parity_mode = 2'b01;
    push1(8'hA5);
    tick_cap(44);
    add_frame(8'hA5, 4, 1, 0);
    cmp_stream("even_frame");
    tick();
    chk("even_busy_fall", busy, 1'b0);
    parity_mode = 2'b10;
    push1(8'hA5);
    tick_cap(44);
    add_frame(8'hA5, 4, 1, 1);
    cmp_stream("odd_frame");
    tick();
    chk("odd_busy_fall", busy, 1'b0);
`else
    parity_mode = 2'b01;
    push1(8'hA5);
    tick_cap(40);
    add_frame(8'hA5, 4, 1, -1);
    cmp_stream("noparity_frame");
    tick();
    chk("noparity_busy_fall", busy, 1'b0);
`endif
    parity_mode = 2'b00;
    tick(2);

    // Five words with s_valid held: first pops at once, four fill the FIFO.
    s_data  = 8'h11;
    s_valid = 1'b1;
    tick();
    s_data = 8'h22; tick_cap(1);
    chk("burst_level1", fifo_level, 3'd1);
    chk("burst_ready1", s_ready, 1'b1);
    s_data = 8'h33; tick_cap(1);
    chk("burst_level2", fifo_level, 3'd2);
    s_data = 8'h44; tick_cap(1);
    chk("burst_level3", fifo_level, 3'd3);
    s_data = 8'h55; tick_cap(1);
    chk("burst_level4", fifo_level, 3'd4);
    chk("burst_ready_full", s_ready, 1'b0);
    s_valid = 1'b0;
    tick_cap(36);
    chk("burst_still_full", s_ready, 1'b0);
    tick_cap(1);
    chk("burst_ready_after_pop", s_ready, 1'b1);
    chk("burst_level_after_pop", fifo_level, 3'd3);
    for (int f = 1; f <= 3; f++) begin
      tick_cap(40);
      chk("burst_countdown", fifo_level, 3'(3 - f));
    end
    tick_cap(39);
    chk("burst_busy_end", busy, 1'b1);
    add_frame(8'h11, 4, 1, -1);
    add_frame(8'h22, 4, 1, -1);
    add_frame(8'h33, 4, 1, -1);
    add_frame(8'h44, 4, 1, -1);
    add_frame(8'h55, 4, 1, -1);
    cmp_stream("burst_stream");
    tick();
    chk("burst_busy_fall", busy, 1'b0);
    tick(2);

    // Divisor 0 clamps to 2 clocks per bit; two stop bits.
    baud_div = 16'd0;
    stop2    = 1'b1;
    push1(8'h00);
    tick_cap(22);
    lows = 0;
    foreach (cap_q[i]) if (cap_q[i] === 1'b0) lows++;
    chk("clamp_low_run", lows, 18);
    add_frame(8'h00, 2, 2, -1);
    cmp_stream("clamp_frame");
    tick();
    chk("clamp_busy_fall", busy, 1'b0);
    baud_div = 16'd4;
    stop2    = 1'b0;
    tick(2);

    // Reset during data bit 3 with two words queued.
    s_valid = 1'b1;
    s_data  = 8'h00; tick();
    s_data  = 8'hF0; tick();
    s_data  = 8'h0F; tick();
    s_valid = 1'b0;
    chk("rst_mid_level_q", fifo_level, 3'd2);
    tick(16);
    chk("rst_mid_bit3_low", tx, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_tx", tx, 1'b1);
    chk("rst_mid_level", fifo_level, 3'd0);
    chk("rst_mid_busy", busy, 1'b0);
    rst_n = 1'b1;
    lows    = 0;
    busy_hi = 0;
    repeat (50) begin
      tick();
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busy_hi++;
    end
    chk("post_rst_tx_quiet", lows, 0);
    chk("post_rst_not_busy", busy_hi, 0);

    // Divisor change mid-frame only affects the next frame.
    push1(8'h3C);
    tick_cap(10);
    baud_div = 16'd8;
    s_data   = 8'hC3;
    s_valid  = 1'b1;
    tick_cap(1);
    s_valid = 1'b0;
    tick_cap(29 + 80);
    add_frame(8'h3C, 4, 1, -1);
    add_frame(8'hC3, 8, 1, -1);
    cmp_stream("div_change");
    tick();
    chk("div_change_busy_fall", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
